aud_i2s_player: RTL and testbench

//  Stage directly downstream of the audio DSP. Serialises its signed 16-bit PCM sample onto the

---
 rtl/aud_pkg.sv | 21 ++
 rtl/aud_i2s_player_if.sv | 35 +++
 rtl/aud_lrck_edge.sv | 28 ++
 rtl/aud_i2s_player.sv | 151 +++++++++++++++
 tb/tb_aud_i2s_player.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aud_pkg.sv
// ============================================================================
// aud_pkg : shared types and defaults for the I2S playback path
// Rev 1.0
// ============================================================================
`default_nettype none

package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_SHIFT = 2'd2,
    S_TAIL  = 2'd3
  } player_state_t;

  localparam int AUD_WIDTH    = 16;
  localparam int AUD_VOL_BITS = 3;

endpackage

`default_nettype wire

// File: rtl/aud_i2s_player_if.sv
// ============================================================================
// aud_i2s_player_if : DSP-side sample/control bus and codec-side serial pin
// Rev 1.0
// ============================================================================
`default_nettype none

interface aud_i2s_player_if
  import aud_pkg::*;
#(
  parameter int WIDTH    = AUD_WIDTH,
  parameter int VOL_BITS = AUD_VOL_BITS
);

  logic                i_en;
  logic                i_daclrck;
  logic [WIDTH-1:0]    i_dac_data;
  logic                i_mute;
  logic [VOL_BITS-1:0] i_vol;
  logic                o_aud_dacdat;
  logic                o_sample_req;
  logic                o_trunc_err;

  modport master (
    output i_en, i_daclrck, i_dac_data, i_mute, i_vol,
    input  o_aud_dacdat, o_sample_req, o_trunc_err
  );

  modport slave (
    input  i_en, i_daclrck, i_dac_data, i_mute, i_vol,
    output o_aud_dacdat, o_sample_req, o_trunc_err
  );

endinterface

`default_nettype wire

// File: rtl/aud_lrck_edge.sv
// ============================================================================
// aud_lrck_edge : registers DACLRCK and flags its rising/falling edges
// Rev 1.0
// ============================================================================
`default_nettype none

module aud_lrck_edge (
  input  logic clk,
  input  logic lrck,
  output logic lrck_edge,
  output logic rise,
  output logic fall
);

  logic r_lrck_d;

  // Reset value equals the live pin, so no reset branch is needed.
  always_ff @(posedge clk) begin
    r_lrck_d <= lrck;
  end

  assign lrck_edge = lrck ^ r_lrck_d;
  assign rise      = lrck_edge & lrck;
  assign fall      = lrck_edge & ~lrck;

endmodule

`default_nettype wire

// File: rtl/aud_i2s_player.sv
// ============================================================================
// aud_i2s_player : serialises one attenuated PCM sample per frame onto DACDAT
//                  in I2S format, same sample on left and right slots
// Rev 1.0
// ============================================================================
`default_nettype none

module aud_i2s_player
  import aud_pkg::*;
#(
  parameter int WIDTH    = AUD_WIDTH,
  parameter int VOL_BITS = AUD_VOL_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  aud_i2s_player_if.slave   bus
);

  localparam int             CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  player_state_t        r_state;
  player_state_t        w_next;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     r_hold;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_dacdat;
  logic                 r_sample_req;
  logic                 r_trunc_err;

  logic                 w_edge;
  logic                 w_rise;
  logic                 w_fall;
  logic signed [WIDTH-1:0] w_scaled;
  logic [WIDTH-1:0]     w_sample;
  logic                 w_latch;
  logic                 w_reload_hold;
  logic                 w_shift;
  logic                 w_trunc;

  aud_lrck_edge u_lrck_edge (
    .clk       (i_clk),
    .lrck      (bus.i_daclrck),
    .lrck_edge (w_edge),
    .rise      (w_rise),
    .fall      (w_fall)
  );

  assign w_scaled = $signed(bus.i_dac_data) >>> bus.i_vol;
  assign w_sample = bus.i_mute ? '0 : w_scaled;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A dropped enable always wins over an LRCK edge: no latch, no reload.
  always_comb begin
    w_next        = r_state;
    w_latch       = 1'b0;
    w_reload_hold = 1'b0;
    w_shift       = 1'b0;
    w_trunc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_en) begin
          w_next = S_SYNC;
        end
      end
      S_SYNC: begin
        if (!bus.i_en) begin
          w_next = S_IDLE;
        end else if (w_fall) begin
          w_latch = 1'b1;
          w_next  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (w_edge) begin
          w_trunc = (r_bit_cnt != C_LAST_BIT);
          if (!bus.i_en) begin
            w_next = S_IDLE;
          end else begin
            w_latch       = w_fall;
            w_reload_hold = w_rise;
            w_next        = S_SHIFT;
          end
        end else if (r_bit_cnt == C_LAST_BIT) begin
          w_next = S_TAIL;
        end
      end
      S_TAIL: begin
        if (w_edge) begin
          if (!bus.i_en) begin
            w_next = S_IDLE;
          end else begin
            w_latch       = w_fall;
            w_reload_hold = w_rise;
            w_next        = S_SHIFT;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The bit driven on the edge cycle still belongs to the previous slot,
  // which yields the one-bit I2S delay for the reloaded MSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift      <= '0;
      r_hold       <= '0;
      r_bit_cnt    <= '0;
      r_dacdat     <= 1'b0;
      r_sample_req <= 1'b0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_sample_req <= w_latch;
      r_dacdat     <= w_shift & r_shift[WIDTH-1];
      if (w_trunc) begin
        r_trunc_err <= 1'b1;
      end
      if (w_latch) begin
        r_hold <= w_sample;
      end
      if (w_latch) begin
        r_shift   <= w_sample;
        r_bit_cnt <= '0;
      end else if (w_reload_hold) begin
        r_shift   <= r_hold;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_aud_dacdat = r_dacdat;
  assign bus.o_sample_req = r_sample_req;
  assign bus.o_trunc_err  = r_trunc_err;

endmodule

`default_nettype wire

// File: tb/tb_aud_i2s_player.sv
// ============================================================================
// tb_aud_i2s_player : directed self-checking bench for aud_i2s_player
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aud_i2s_player;
  import aud_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   half;
  int   phase;
  int   since;

  aud_i2s_player_if #(.WIDTH(16), .VOL_BITS(3)) bus ();

  aud_i2s_player #(.WIDTH(16), .VOL_BITS(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bit-clock cycle; LRCK toggles every 'half' cycles, 'since' counts
  // cycles from the latest toggle (0 = toggle just applied).
  task automatic cyc();
    @(posedge clk);
    #1;
    since++;
    phase++;
    if (phase >= half) begin
      phase = 0;
      since = 0;
      bus.i_daclrck = ~bus.i_daclrck;
    end
  endtask

  task automatic restart(input logic lvl, input int h, input logic en,
                         input logic [15:0] d, input logic [2:0] v, input logic m);
    rst            = 1'b1;
    bus.i_daclrck  = lvl;
    half           = h;
    phase          = 0;
    since          = 1000;
    bus.i_en       = en;
    bus.i_dac_data = d;
    bus.i_vol      = v;
    bus.i_mute     = m;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (since == 0 && bus.i_daclrck == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected DACDAT for a full-length slot (half period >= 18).
  function automatic logic exp32(input logic [15:0] w, input int s);
    if (s >= 2 && s <= 17) return w[17-s];
    return 1'b0;
  endfunction

  // Expected DACDAT for 10-cycle slots, k counted from the first fall toggle.
  function automatic logic exp_tr(input logic [15:0] w, input int k);
    if (k < 2) return 1'b0;
    return w[15 - ((k - 2) % 10)];
  endfunction

  task automatic test_reset();
    restart(1'b1, 32, 1'b0, 16'h0000, 3'd0, 1'b0);
    checks++; if (bus.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat: got %b expected 0", bus.o_aud_dacdat); end
    checks++; if (bus.o_sample_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.o_sample_req); end
    checks++; if (bus.o_trunc_err !== 1'b0) begin errors++; $display("FAIL reset_trunc: got %b expected 0", bus.o_trunc_err); end
    checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, S_IDLE); end
    bus.i_en = 1'b1;
    cyc();
    checks++; if (dut.r_state !== S_SYNC) begin errors++; $display("FAIL reset_to_sync: got %0d expected %0d", dut.r_state, S_SYNC); end
  endtask

  task automatic test_basic();
    bit ok;
    int pulses;
    logic e;
    logic re;
    restart(1'b1, 32, 1'b1, 16'hA5C3, 3'd0, 1'b0);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_wait: got no fall expected fall"); end
    pulses = 0;
    for (int k = 0; k < 128; k++) begin
      e  = exp32(16'hA5C3, since);
      re = (since == 1) && (bus.i_daclrck == 1'b0);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL basic_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_sample_req !== re) begin errors++; $display("FAIL basic_req k=%0d: got %b expected %b", k, bus.o_sample_req, re); end
      if (bus.o_sample_req === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL basic_req_count: got %0d expected 2", pulses); end
  endtask

  task automatic test_atten();
    bit ok;
    logic [15:0] w;
    logic e;
    logic re;
    restart(1'b1, 32, 1'b1, 16'h8000, 3'd3, 1'b0);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL atten_wait: got no fall expected fall"); end
    for (int k = 0; k < 192; k++) begin
      w  = (k < 64) ? 16'hF000 : ((k < 128) ? 16'h0000 : 16'h00FF);
      e  = exp32(w, since);
      re = ((k % 64) == 1);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL atten_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_sample_req !== re) begin errors++; $display("FAIL atten_req k=%0d: got %b expected %b", k, bus.o_sample_req, re); end
      if (k == 32) bus.i_mute = 1'b1;
      if (k == 96) begin
        bus.i_mute     = 1'b0;
        bus.i_dac_data = 16'h7FFF;
        bus.i_vol      = 3'd7;
      end
      cyc();
    end
  endtask

  task automatic test_trunc();
    bit ok;
    logic e;
    logic re;
    logic te;
    restart(1'b1, 10, 1'b1, 16'hA5C3, 3'd0, 1'b0);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL trunc_wait: got no fall expected fall"); end
    for (int k = 0; k < 40; k++) begin
      e  = exp_tr(16'hA5C3, k);
      re = ((k % 20) == 1);
      te = (k >= 11);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL trunc_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_sample_req !== re) begin errors++; $display("FAIL trunc_req k=%0d: got %b expected %b", k, bus.o_sample_req, re); end
      checks++; if (bus.o_trunc_err !== te) begin errors++; $display("FAIL trunc_flag k=%0d: got %b expected %b", k, bus.o_trunc_err, te); end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic e;
    logic te;
    restart(1'b1, 10, 1'b1, 16'hA5C3, 3'd0, 1'b0);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_wait: got no fall expected fall"); end
    repeat (15) cyc();
    checks++; if (bus.o_trunc_err !== 1'b1) begin errors++; $display("FAIL rmid_trunc_pre: got %b expected 1", bus.o_trunc_err); end
    checks++; if (dut.r_state !== S_SHIFT) begin errors++; $display("FAIL rmid_state_pre: got %0d expected %0d", dut.r_state, S_SHIFT); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL rmid_dacdat i=%0d: got %b expected 0", i, bus.o_aud_dacdat); end
      checks++; if (bus.o_trunc_err !== 1'b0) begin errors++; $display("FAIL rmid_trunc i=%0d: got %b expected 0", i, bus.o_trunc_err); end
      checks++; if (bus.o_sample_req !== 1'b0) begin errors++; $display("FAIL rmid_req i=%0d: got %b expected 0", i, bus.o_sample_req); end
      checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL rmid_state i=%0d: got %0d expected %0d", i, dut.r_state, S_IDLE); end
    end
    rst = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (since == 0 && bus.i_daclrck == 1'b0) begin
        ok = 1'b1;
        break;
      end
      checks++; if (bus.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL rmid_idle_bit i=%0d: got %b expected 0", i, bus.o_aud_dacdat); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_refall: got no fall expected fall"); end
    for (int k = 0; k < 24; k++) begin
      e  = exp_tr(16'hA5C3, k);
      te = (k >= 11);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL rmid_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_trunc_err !== te) begin errors++; $display("FAIL rmid_flag k=%0d: got %b expected %b", k, bus.o_trunc_err, te); end
      cyc();
    end
  endtask

  task automatic test_align();
    bit ok;
    logic e;
    logic re;
    restart(1'b0, 32, 1'b0, 16'hA5C3, 3'd0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (since == 0 && bus.i_daclrck == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL align_rise: got no rise expected rise"); end
    repeat (5) cyc();
    bus.i_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (since == 0 && bus.i_daclrck == 1'b0) begin
        ok = 1'b1;
        break;
      end
      checks++; if (bus.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL align_early_bit i=%0d: got %b expected 0", i, bus.o_aud_dacdat); end
      checks++; if (bus.o_sample_req !== 1'b0) begin errors++; $display("FAIL align_early_req i=%0d: got %b expected 0", i, bus.o_sample_req); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL align_fall: got no fall expected fall"); end
    checks++; if (dut.r_state !== S_SYNC) begin errors++; $display("FAIL align_state: got %0d expected %0d", dut.r_state, S_SYNC); end
    for (int k = 0; k < 32; k++) begin
      e  = exp32(16'hA5C3, since);
      re = (k == 1);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL align_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_sample_req !== re) begin errors++; $display("FAIL align_req k=%0d: got %b expected %b", k, bus.o_sample_req, re); end
      cyc();
    end
  endtask

  task automatic test_stop();
    bit ok;
    logic e;
    logic re;
    restart(1'b1, 32, 1'b1, 16'hA5C3, 3'd0, 1'b0);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_wait: got no fall expected fall"); end
    for (int k = 0; k < 128; k++) begin
      e  = (k < 32) ? exp32(16'hA5C3, since) : 1'b0;
      re = (k == 1);
      checks++; if (bus.o_aud_dacdat !== e) begin errors++; $display("FAIL stop_bit k=%0d: got %b expected %b", k, bus.o_aud_dacdat, e); end
      checks++; if (bus.o_sample_req !== re) begin errors++; $display("FAIL stop_req k=%0d: got %b expected %b", k, bus.o_sample_req, re); end
      if (k == 20) begin
        checks++; if (dut.r_state !== S_TAIL) begin errors++; $display("FAIL stop_tail: got %0d expected %0d", dut.r_state, S_TAIL); end
      end
      if (k == 33) begin
        checks++; if (dut.r_state !== S_IDLE) begin errors++; $display("FAIL stop_idle: got %0d expected %0d", dut.r_state, S_IDLE); end
      end
      if (k == 6) bus.i_en = 1'b0;
      cyc();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    half   = 32;
    phase  = 0;
    since  = 1000;
    bus.i_en       = 1'b0;
    bus.i_daclrck  = 1'b1;
    bus.i_dac_data = 16'h0000;
    bus.i_mute     = 1'b0;
    bus.i_vol      = 3'd0;
    test_reset();
    test_basic();
    test_atten();
    test_trunc();
    test_reset_mid();
    test_align();
    test_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
